// File: rtl/rvh_dtlb_miss_queue.sv
// rtl/rvh_dtlb_miss_queue.sv - DTLB miss queue: buffers misses, issues one walk at a time to the MMU.
// Optional request merging on matching {asid, vpn} is enabled by defining DTLB_MISS_MERGE_EN.
module rvh_dtlb_miss_queue #(
    parameter int ENTRY_COUNT    = 4,
    parameter int TRANS_ID_WIDTH = 3,
    parameter int VPN_WIDTH      = 27,
    parameter int ASID_WIDTH     = 16,
    parameter int PTE_WIDTH      = 64,
    parameter int PAGE_LVL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dtlb_miss_req_vld_i,
    input  logic [TRANS_ID_WIDTH-1:0] dtlb_miss_req_trans_id_i,
    input  logic [ASID_WIDTH-1:0]     dtlb_miss_req_asid_i,
    input  logic [VPN_WIDTH-1:0]      dtlb_miss_req_vpn_i,
    input  logic [1:0]                dtlb_miss_req_access_type_i,
    output logic                      dtlb_miss_req_rdy_o,
    output logic                      dtlb_miss_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] dtlb_miss_resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]     dtlb_miss_resp_asid_o,
    output logic [PTE_WIDTH-1:0]      dtlb_miss_resp_pte_o,
    output logic [PAGE_LVL_WIDTH-1:0] dtlb_miss_resp_page_lvl_o,
    output logic [VPN_WIDTH-1:0]      dtlb_miss_resp_vpn_o,
    output logic [1:0]                dtlb_miss_resp_access_type_o,
    output logic                      dtlb_miss_resp_access_fault_o,
    output logic                      dtlb_miss_resp_page_fault_o,
    output logic                      mmu_miss_req_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] mmu_miss_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]     mmu_miss_req_asid_o,
    output logic [VPN_WIDTH-1:0]      mmu_miss_req_vpn_o,
    output logic [1:0]                mmu_miss_req_access_type_o,
    input  logic                      mmu_miss_req_rdy_i,
    input  logic                      mmu_miss_resp_vld_i,
    input  logic [TRANS_ID_WIDTH-1:0] mmu_miss_resp_trans_id_i,
    input  logic [ASID_WIDTH-1:0]     mmu_miss_resp_asid_i,
    input  logic [PTE_WIDTH-1:0]      mmu_miss_resp_pte_i,
    input  logic [PAGE_LVL_WIDTH-1:0] mmu_miss_resp_page_lvl_i,
    input  logic [VPN_WIDTH-1:0]      mmu_miss_resp_vpn_i,
    input  logic [1:0]                mmu_miss_resp_access_type_i,
    input  logic                      mmu_miss_resp_access_fault_i,
    input  logic                      mmu_miss_resp_page_fault_i,
    input  logic                      flush_i
);
    localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;

    typedef enum logic [2:0] {S_FREE, S_PEND, S_ISSUED, S_KILLED, S_WAIT, S_REPLAY} entry_state_e;

    entry_state_e              state_q [ENTRY_COUNT];
    logic [TRANS_ID_WIDTH-1:0] tid_q   [ENTRY_COUNT];
    logic [ASID_WIDTH-1:0]     asid_q  [ENTRY_COUNT];
    logic [VPN_WIDTH-1:0]      vpn_q   [ENTRY_COUNT];
    logic [1:0]                at_q    [ENTRY_COUNT];
    // age_q[i][j] set means entry i was allocated before entry j
    logic [ENTRY_COUNT-1:0]    age_q   [ENTRY_COUNT];
    logic                      outstanding_q;

    logic [ENTRY_COUNT-1:0] free_vec, pend_vec, issued_vec, killed_vec, resp_hit_vec, has_older;
    logic [ENTRY_COUNT-1:0] wait_to_replay, wait_to_free, replay_done;
    logic [IDX_W-1:0]       alloc_idx, issue_idx, resp_idx;
    logic accept, issue_fire, resp_issued, resp_killed, resp_fwd, alloc_wait, replay_block;

    always_comb begin
        free_vec     = '0;
        pend_vec     = '0;
        issued_vec   = '0;
        killed_vec   = '0;
        resp_hit_vec = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            free_vec[i]     = (state_q[i] == S_FREE);
            pend_vec[i]     = (state_q[i] == S_PEND);
            issued_vec[i]   = (state_q[i] == S_ISSUED);
            killed_vec[i]   = (state_q[i] == S_KILLED);
            resp_hit_vec[i] = mmu_miss_resp_vld_i &&
                              (mmu_miss_resp_trans_id_i == TRANS_ID_WIDTH'(i));
        end
    end

    always_comb begin
        has_older = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            for (int j = 0; j < ENTRY_COUNT; j++) begin
                if (j != i && pend_vec[j] && age_q[j][i]) has_older[i] = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        resp_idx  = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = IDX_W'(i);
            if (pend_vec[i] && !has_older[i]) issue_idx = IDX_W'(i);
            if (resp_hit_vec[i]) resp_idx = IDX_W'(i);
        end
    end

    assign dtlb_miss_req_rdy_o = (|free_vec) & ~flush_i & ~rst;
    assign accept              = dtlb_miss_req_vld_i & dtlb_miss_req_rdy_o;
    assign resp_issued         = |(resp_hit_vec & issued_vec);
    assign resp_killed         = |(resp_hit_vec & killed_vec);
    // A response that races a flush is dropped, but still frees its entry
    assign resp_fwd            = resp_issued & ~flush_i & ~rst;

    assign mmu_miss_req_vld_o         = (|pend_vec) & ~outstanding_q & ~replay_block & ~rst;
    assign issue_fire                 = mmu_miss_req_vld_o & mmu_miss_req_rdy_i;
    assign mmu_miss_req_trans_id_o    = mmu_miss_req_vld_o ? TRANS_ID_WIDTH'(issue_idx) : '0;
    assign mmu_miss_req_asid_o        = mmu_miss_req_vld_o ? asid_q[issue_idx] : '0;
    assign mmu_miss_req_vpn_o         = mmu_miss_req_vld_o ? vpn_q[issue_idx] : '0;
    assign mmu_miss_req_access_type_o = mmu_miss_req_vld_o ? at_q[issue_idx] : '0;

`ifdef DTLB_MISS_MERGE_EN
    logic [IDX_W-1:0]          link_q [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0]    match_vec, replay_vec;
    logic [IDX_W-1:0]          match_idx, replay_idx;
    logic                      replay_fire;
    logic [PTE_WIDTH-1:0]      res_pte_q;
    logic [PAGE_LVL_WIDTH-1:0] res_lvl_q;
    logic [ASID_WIDTH-1:0]     res_asid_q;
    logic [VPN_WIDTH-1:0]      res_vpn_q;
    logic                      res_af_q, res_pf_q;

    always_comb begin
        match_vec      = '0;
        replay_vec     = '0;
        wait_to_replay = '0;
        wait_to_free   = '0;
        match_idx      = '0;
        replay_idx     = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            // a leader answered this cycle cannot take new followers
            match_vec[i]      = (pend_vec[i] || (issued_vec[i] && !resp_hit_vec[i])) &&
                                (asid_q[i] == dtlb_miss_req_asid_i) &&
                                (vpn_q[i] == dtlb_miss_req_vpn_i);
            replay_vec[i]     = (state_q[i] == S_REPLAY);
            wait_to_replay[i] = (state_q[i] == S_WAIT) && resp_issued && (link_q[i] == resp_idx);
            wait_to_free[i]   = (state_q[i] == S_WAIT) && resp_killed && (link_q[i] == resp_idx);
        end
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = IDX_W'(i);
            if (replay_vec[i]) replay_idx = IDX_W'(i);
        end
    end

    assign alloc_wait   = |match_vec;
    assign replay_block = |replay_vec;
    assign replay_fire  = replay_block & ~resp_fwd & ~flush_i & ~rst;

    always_comb begin
        replay_done = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            replay_done[i] = replay_fire && (replay_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_pte_q  <= '0;
            res_lvl_q  <= '0;
            res_asid_q <= '0;
            res_vpn_q  <= '0;
            res_af_q   <= 1'b0;
            res_pf_q   <= 1'b0;
        end else if (resp_fwd) begin
            res_pte_q  <= mmu_miss_resp_pte_i;
            res_lvl_q  <= mmu_miss_resp_page_lvl_i;
            res_asid_q <= mmu_miss_resp_asid_i;
            res_vpn_q  <= mmu_miss_resp_vpn_i;
            res_af_q   <= mmu_miss_resp_access_fault_i;
            res_pf_q   <= mmu_miss_resp_page_fault_i;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) link_q[alloc_idx] <= match_idx;
    end
`else
    assign alloc_wait     = 1'b0;
    assign replay_block   = 1'b0;
    assign wait_to_replay = '0;
    assign wait_to_free   = '0;
    assign replay_done    = '0;
`endif

    always_comb begin
        dtlb_miss_resp_vld_o          = 1'b0;
        dtlb_miss_resp_trans_id_o     = '0;
        dtlb_miss_resp_asid_o         = '0;
        dtlb_miss_resp_pte_o          = '0;
        dtlb_miss_resp_page_lvl_o     = '0;
        dtlb_miss_resp_vpn_o          = '0;
        dtlb_miss_resp_access_type_o  = '0;
        dtlb_miss_resp_access_fault_o = 1'b0;
        dtlb_miss_resp_page_fault_o   = 1'b0;
        if (resp_fwd) begin
            dtlb_miss_resp_vld_o          = 1'b1;
            dtlb_miss_resp_trans_id_o     = tid_q[resp_idx];
            dtlb_miss_resp_asid_o         = mmu_miss_resp_asid_i;
            dtlb_miss_resp_pte_o          = mmu_miss_resp_pte_i;
            dtlb_miss_resp_page_lvl_o     = mmu_miss_resp_page_lvl_i;
            dtlb_miss_resp_vpn_o          = mmu_miss_resp_vpn_i;
            dtlb_miss_resp_access_type_o  = mmu_miss_resp_access_type_i;
            dtlb_miss_resp_access_fault_o = mmu_miss_resp_access_fault_i;
            dtlb_miss_resp_page_fault_o   = mmu_miss_resp_page_fault_i;
        end
`ifdef DTLB_MISS_MERGE_EN
        else if (replay_fire) begin
            dtlb_miss_resp_vld_o          = 1'b1;
            dtlb_miss_resp_trans_id_o     = tid_q[replay_idx];
            dtlb_miss_resp_asid_o         = res_asid_q;
            dtlb_miss_resp_pte_o          = res_pte_q;
            dtlb_miss_resp_page_lvl_o     = res_lvl_q;
            dtlb_miss_resp_vpn_o          = res_vpn_q;
            dtlb_miss_resp_access_type_o  = at_q[replay_idx];
            dtlb_miss_resp_access_fault_o = res_af_q;
            dtlb_miss_resp_page_fault_o   = res_pf_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) state_q[i] <= S_FREE;
            outstanding_q <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                if (flush_i) begin
                    case (state_q[i])
                        // a handshake racing the flush still leaves a walk in flight
                        S_PEND:           state_q[i] <= (issue_fire && issue_idx == IDX_W'(i)) ? S_KILLED : S_FREE;
                        S_WAIT, S_REPLAY: state_q[i] <= S_FREE;
                        S_ISSUED:         state_q[i] <= resp_hit_vec[i] ? S_FREE : S_KILLED;
                        S_KILLED:         if (resp_hit_vec[i]) state_q[i] <= S_FREE;
                        default:          ;
                    endcase
                end else begin
                    case (state_q[i])
                        S_FREE:   if (accept && alloc_idx == IDX_W'(i)) state_q[i] <= alloc_wait ? S_WAIT : S_PEND;
                        S_PEND:   if (issue_fire && issue_idx == IDX_W'(i)) state_q[i] <= S_ISSUED;
                        S_ISSUED, S_KILLED: if (resp_hit_vec[i]) state_q[i] <= S_FREE;
                        S_WAIT: begin
                            if (wait_to_replay[i])    state_q[i] <= S_REPLAY;
                            else if (wait_to_free[i]) state_q[i] <= S_FREE;
                        end
                        S_REPLAY: if (replay_done[i]) state_q[i] <= S_FREE;
                        default:  ;
                    endcase
                end
            end
            if (resp_issued || resp_killed) outstanding_q <= 1'b0;
            if (issue_fire) outstanding_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tid_q[alloc_idx]  <= dtlb_miss_req_trans_id_i;
            asid_q[alloc_idx] <= dtlb_miss_req_asid_i;
            vpn_q[alloc_idx]  <= dtlb_miss_req_vpn_i;
            at_q[alloc_idx]   <= dtlb_miss_req_access_type_i;
            for (int j = 0; j < ENTRY_COUNT; j++) age_q[j][alloc_idx] <= 1'b1;
            for (int j = 0; j < ENTRY_COUNT; j++) age_q[alloc_idx][j] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rvh_dtlb_miss_queue.sv
// tb/tb_rvh_dtlb_miss_queue.sv - directed self-checking bench for rvh_dtlb_miss_queue.
module tb_rvh_dtlb_miss_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic [2:0]  req_tid;
    logic [15:0] req_asid;
    logic [26:0] req_vpn;
    logic [1:0]  req_at;
    logic        req_rdy;
    logic        resp_vld;
    logic [2:0]  resp_tid;
    logic [15:0] resp_asid;
    logic [63:0] resp_pte;
    logic [1:0]  resp_lvl;
    logic [26:0] resp_vpn;
    logic [1:0]  resp_at;
    logic        resp_af, resp_pf;
    logic        mreq_vld;
    logic [2:0]  mreq_tid;
    logic [15:0] mreq_asid;
    logic [26:0] mreq_vpn;
    logic [1:0]  mreq_at;
    logic        mreq_rdy;
    logic        mresp_vld;
    logic [2:0]  mresp_tid;
    logic [15:0] mresp_asid;
    logic [63:0] mresp_pte;
    logic [1:0]  mresp_lvl;
    logic [26:0] mresp_vpn;
    logic [1:0]  mresp_at;
    logic        mresp_af, mresp_pf;
    logic        flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rvh_dtlb_miss_queue dut (
        .clk(clk), .rst(rst),
        .dtlb_miss_req_vld_i(req_vld), .dtlb_miss_req_trans_id_i(req_tid),
        .dtlb_miss_req_asid_i(req_asid), .dtlb_miss_req_vpn_i(req_vpn),
        .dtlb_miss_req_access_type_i(req_at), .dtlb_miss_req_rdy_o(req_rdy),
        .dtlb_miss_resp_vld_o(resp_vld), .dtlb_miss_resp_trans_id_o(resp_tid),
        .dtlb_miss_resp_asid_o(resp_asid), .dtlb_miss_resp_pte_o(resp_pte),
        .dtlb_miss_resp_page_lvl_o(resp_lvl), .dtlb_miss_resp_vpn_o(resp_vpn),
        .dtlb_miss_resp_access_type_o(resp_at), .dtlb_miss_resp_access_fault_o(resp_af),
        .dtlb_miss_resp_page_fault_o(resp_pf),
        .mmu_miss_req_vld_o(mreq_vld), .mmu_miss_req_trans_id_o(mreq_tid),
        .mmu_miss_req_asid_o(mreq_asid), .mmu_miss_req_vpn_o(mreq_vpn),
        .mmu_miss_req_access_type_o(mreq_at), .mmu_miss_req_rdy_i(mreq_rdy),
        .mmu_miss_resp_vld_i(mresp_vld), .mmu_miss_resp_trans_id_i(mresp_tid),
        .mmu_miss_resp_asid_i(mresp_asid), .mmu_miss_resp_pte_i(mresp_pte),
        .mmu_miss_resp_page_lvl_i(mresp_lvl), .mmu_miss_resp_vpn_i(mresp_vpn),
        .mmu_miss_resp_access_type_i(mresp_at), .mmu_miss_resp_access_fault_i(mresp_af),
        .mmu_miss_resp_page_fault_i(mresp_pf),
        .flush_i(flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] tid, input logic [15:0] asid, input logic [26:0] vpn,
                       input logic [1:0] at);
        req_vld = 1'b1; req_tid = tid; req_asid = asid; req_vpn = vpn; req_at = at;
    endtask

    task automatic mresp(input logic [2:0] tid, input logic [63:0] pte, input logic [26:0] vpn,
                         input logic [15:0] asid);
        mresp_vld = 1'b1; mresp_tid = tid; mresp_pte = pte; mresp_vpn = vpn; mresp_asid = asid;
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_tid = '0; req_asid = '0; req_vpn = '0; req_at = '0;
        mreq_rdy = 1'b0; mresp_vld = 1'b0; mresp_tid = '0; mresp_asid = '0; mresp_pte = '0;
        mresp_lvl = '0; mresp_vpn = '0; mresp_at = '0; mresp_af = 1'b0; mresp_pf = 1'b0;
        flush = 1'b0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("reset_rdy", req_rdy, 1);
        chk("reset_mreq_vld", mreq_vld, 0);
        chk("reset_resp_vld", resp_vld, 0);
        chk("reset_mreq_vpn", mreq_vpn, 0);
        chk("reset_resp_pte", resp_pte, 0);

        // single miss
        req(3'd5, 16'd0, 27'h123, 2'd0); #1;
        chk("single_rdy", req_rdy, 1);
        chk("single_no_early_issue", mreq_vld, 0);
        tick(); req_vld = 1'b0; #1;
        chk("single_mreq_vld", mreq_vld, 1);
        chk("single_mreq_tid", mreq_tid, 0);
        chk("single_mreq_vpn", mreq_vpn, 27'h123);
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0; #1;
        chk("single_outstanding", mreq_vld, 0);
        mresp(3'd0, 64'hABCD, 27'h123, 16'd0); mresp_lvl = 2'd1; #1;
        chk("single_resp_vld", resp_vld, 1);
        chk("single_resp_tid", resp_tid, 5);
        chk("single_resp_pte", resp_pte, 64'hABCD);
        chk("single_resp_lvl", resp_lvl, 1);
        tick(); mresp_vld = 1'b0; mresp_lvl = '0; #1;
        chk("single_resp_idle", resp_vld, 0);
        chk("single_resp_tid_zero", resp_tid, 0);

        // full queue and ordering
        for (int k = 0; k < 4; k++) begin
            req(3'(k + 1), 16'd0, 27'(k + 1), 2'd0); #1;
            chk("fill_rdy", req_rdy, 1);
            tick();
        end
        req_vld = 1'b0; #1;
        chk("full_rdy", req_rdy, 0);
        chk("order_a_tid", mreq_tid, 0);
        chk("order_a_vpn", mreq_vpn, 1);
        tick(); #1;
        chk("stable_vld", mreq_vld, 1);
        chk("stable_vpn", mreq_vpn, 1);
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0; #1;
        chk("one_outstanding", mreq_vld, 0);
        mresp(3'd0, 64'h1111, 27'd1, 16'd0); #1;
        chk("resp_a_tid", resp_tid, 1);
        chk("freed_not_yet_rdy", req_rdy, 0);
        tick(); mresp_vld = 1'b0; #1;
        chk("freed_rdy", req_rdy, 1);
        chk("order_b_vpn", mreq_vpn, 2);
        req(3'd7, 16'd0, 27'd9, 2'd1); tick(); req_vld = 1'b0; #1;
        chk("age_b_tid", mreq_tid, 1);
        chk("age_b_vpn", mreq_vpn, 2);
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0;
        mresp(3'd1, 64'h2222, 27'd2, 16'd0); #1;
        chk("resp_b_tid", resp_tid, 2);
        tick(); mresp_vld = 1'b0; #1;
        chk("order_c_tid", mreq_tid, 2);
        chk("order_c_vpn", mreq_vpn, 3);

        // flush with C issued and two entries pending
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0;
        flush = 1'b1; req(3'd3, 16'd0, 27'h77, 2'd0); #1;
        chk("flush_rdy", req_rdy, 0);
        tick(); flush = 1'b0; req_vld = 1'b0; #1;
        chk("flush_pend_gone", mreq_vld, 0);
        chk("flush_rdy_after", req_rdy, 1);
        mresp(3'd2, 64'h3333, 27'd3, 16'd0); #1;
        chk("killed_resp_vld", resp_vld, 0);
        chk("killed_resp_pte", resp_pte, 0);
        tick(); mresp_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req(3'(k), 16'd0, 27'(27'h100 + k), 2'd0); #1;
            chk("refill_rdy", req_rdy, 1);
            tick();
        end
        req_vld = 1'b0; #1;
        chk("refill_full", req_rdy, 0);
        chk("refill_mreq_vld", mreq_vld, 1);
        chk("refill_mreq_vpn", mreq_vpn, 27'h100);

        // reset while an entry is issued
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst_mid_rdy", req_rdy, 1);
        chk("rst_mid_mreq_vld", mreq_vld, 0);
        chk("rst_mid_resp_vld", resp_vld, 0);
        mresp(3'd0, 64'h4444, 27'h100, 16'd0); #1;
        chk("stale_resp_vld", resp_vld, 0);
        tick(); mresp_vld = 1'b0; #1;
        chk("stale_mreq_vld", mreq_vld, 0);
        chk("stale_rdy", req_rdy, 1);

`ifdef DTLB_MISS_MERGE_EN
        req(3'd2, 16'd1, 27'h40, 2'd0); tick();
        req(3'd6, 16'd1, 27'h40, 2'd1); tick(); req_vld = 1'b0; #1;
        chk("merge_mreq_tid", mreq_tid, 0);
        mreq_rdy = 1'b1; tick(); mreq_rdy = 1'b0; #1;
        chk("merge_single_walk", mreq_vld, 0);
        mresp(3'd0, 64'h55, 27'h40, 16'd1); #1;
        chk("merge_lead_tid", resp_tid, 2);
        chk("merge_lead_pte", resp_pte, 64'h55);
        tick(); mresp_vld = 1'b0; #1;
        chk("merge_replay_vld", resp_vld, 1);
        chk("merge_replay_tid", resp_tid, 6);
        chk("merge_replay_pte", resp_pte, 64'h55);
        chk("merge_replay_at", resp_at, 1);
        tick(); #1;
        chk("merge_done", resp_vld, 0);
        chk("merge_no_second_walk", mreq_vld, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
